register_access_arbiter: RTL and testbench

- Shares one WIDTH-bit register (synchronous reset/set/load, priority reset > set > load) among NREQ requesters.
- Round-robin arbitration grants one requester per transaction.
- The controller drives the register's D/reset/set/load controls for exactly one cycle, captures the resulting Q, and returns it with a one-cycle ack.
- Sits between bus-side requesters and the register datapath; it is the only driver of the register's control inputs.

---
 rtl/register_access_arbiter.sv | 84 ++++++++
 tb/tb_register_access_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/register_access_arbiter.sv
// register_access_arbiter: round-robin arbiter that runs one register op per grant and acks with the result
module register_access_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        rdata,
  output logic                    busy,
  output logic [WIDTH-1:0]        reg_D,
  output logic                    reg_load,
  output logic                    reg_set,
  output logic                    reg_reset,
  input  logic [WIDTH-1:0]        reg_Q
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, grant, pick, idx;
  logic [1:0] pick_op;
  logic found;
  // first pending request after the last winner, wrapping around
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign pick_op = op[2*pick +: 2];
  // transaction sequencer: arbitrate, issue one control cycle, capture Q, ack
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= IW'(NREQ-1);
      grant     <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      reg_D     <= '0;
      reg_load  <= 1'b0;
      reg_set   <= 1'b0;
      reg_reset <= 1'b0;
    end else begin
      ack       <= '0;
      reg_load  <= 1'b0;
      reg_set   <= 1'b0;
      reg_reset <= 1'b0;
      case (state)
        IDLE, ACK: begin
          if (found) begin
            grant     <= pick;
            rr_ptr    <= pick;
            reg_D     <= wdata[WIDTH*pick +: WIDTH];
            reg_load  <= pick_op == 2'b01;
            reg_set   <= pick_op == 2'b10;
            reg_reset <= pick_op == 2'b11;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rdata      <= reg_Q;
          ack[grant] <= 1'b1;
          state      <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_access_arbiter.sv
// tb_register_access_arbiter: directed checks of arbitration order, op issue, capture and reset abort
module tb_register_access_arbiter;
  localparam int W = 4, N = 4;
  logic Clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] op = '0;
  logic [W*N-1:0] wdata = '0;
  logic [N-1:0] ack;
  logic [W-1:0] rdata, reg_D;
  logic [W-1:0] reg_Q = '0;
  logic busy, reg_load, reg_set, reg_reset;
  int n_chk = 0, n_fail = 0;

  register_access_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .Clk(Clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .reg_D(reg_D),
    .reg_load(reg_load), .reg_set(reg_set), .reg_reset(reg_reset), .reg_Q(reg_Q)
  );

  always #5 Clk = ~Clk;

  // behavioural register: sync reset > set > load
  always @(posedge Clk)
    if (reg_reset) reg_Q <= '0;
    else if (reg_set) reg_Q <= '1;
    else if (reg_load) reg_Q <= reg_D;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input int exp_cyc);
    int c = 0;
    do begin
      @(negedge Clk);
      c++;
    end while (ack == '0 && c < 12);
    chk({tag, "_ack_delay"}, c, exp_cyc);
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] d);
    op[2*i +: 2] = o;
    wdata[W*i +: W] = d;
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    repeat (2) @(negedge Clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_D", reg_D, 0);
    chk("rst_ctl", {reg_load, reg_set, reg_reset}, 0);
    reset = 1'b1;
  endtask

  // ctl is {load,set,reset} expected during ISSUE
  task automatic txn(input int i, input logic [1:0] o, input logic [W-1:0] d,
                     input logic [2:0] ctl, input logic [W-1:0] exp, input bit mutate);
    set_req(i, o, d);
    @(negedge Clk);
    chk("issue_ctl", {reg_load, reg_set, reg_reset}, ctl);
    chk("issue_D", reg_D, d);
    chk("issue_busy", busy, 1);
    if (mutate) begin
      op[2*i +: 2] = 2'b11;
      wdata[W*i +: W] = 4'b1100;
    end
    @(negedge Clk);
    chk("capture_ctl", {reg_load, reg_set, reg_reset}, 0);
    wait_ack("txn", 1);
    chk("txn_ack", ack, 1 << i);
    chk("txn_rdata", rdata, exp);
    req[i] = 1'b0;
    @(negedge Clk);
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack, 0);
    chk("rdata_hold", rdata, exp);
  endtask

  initial begin
    logic [W-1:0] e2 [4] = '{4'b1001, 4'b1111, 4'b0000, 4'b0000};
    int seq [4] = '{1, 2, 1, 2};
    // reset state and a single load
    do_reset();
    txn(0, 2'b01, 4'b0101, 3'b100, 4'b0101, 1'b0);
    // all four request at once: order 0..3, 3 cycles apart
    do_reset();
    op = {2'b00, 2'b11, 2'b10, 2'b01};
    wdata = {4'b0000, 4'b0000, 4'b0000, 4'b1001};
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      wait_ack("rr", 3);
      chk("rr_ack", ack, 1 << g);
      chk("rr_rdata", rdata, e2[g]);
      req[g] = 1'b0;
    end
    @(negedge Clk);
    chk("rr_idle", busy, 0);
    // fairness: req1 held, req2 joins, grants alternate
    op = '0;
    req = 4'b0010;
    @(negedge Clk);
    req[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack("fair", k == 0 ? 2 : 3);
      chk("fair_ack", ack, 1 << seq[k]);
    end
    req = '0;
    @(negedge Clk);
    chk("fair_idle", busy, 0);
    // read after load drives no control
    txn(3, 2'b01, 4'b0110, 3'b100, 4'b0110, 1'b0);
    txn(3, 2'b00, 4'b0110, 3'b000, 4'b0110, 1'b0);
    // op/wdata changed after grant are ignored
    txn(0, 2'b01, 4'b0011, 3'b100, 4'b0011, 1'b1);
    // reset during ISSUE of a set aborts without ack
    set_req(0, 2'b10, 4'b0011);
    @(negedge Clk);
    chk("abort_set_before", reg_set, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_set_after", reg_set, 0);
    chk("abort_busy", busy, 0);
    chk("abort_D", reg_D, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("abort_no_ack", ack, 0);
    end
    op = '0;
    req = 4'b1001;
    reset = 1'b1;
    wait_ack("post_rst0", 3);
    chk("post_rst_ack0", ack, 4'b0001);
    chk("post_rst_rdata0", rdata, 4'b0011);
    req[0] = 1'b0;
    wait_ack("post_rst3", 3);
    chk("post_rst_ack3", ack, 4'b1000);
    chk("post_rst_rdata3", rdata, 4'b0011);
    req = '0;
    @(negedge Clk);
    chk("final_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
